// File: rtl/hog_gradient_if.sv
// Stream bundle for hog_gradient: pixel input stream and gradient output stream.
// master = environment side (drives pixels, accepts results), slave = the block.
interface hog_gradient_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MAG_WIDTH  = DATA_WIDTH + 1
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] pixel;
  logic                  in_ready;
  logic                  out_ready;
  logic                  out_valid;
  logic [MAG_WIDTH-1:0]  magnitude;
  logic [3:0]            bin;
  logic                  out_last;

  modport master (output in_valid, pixel, out_ready,
                  input  in_ready, out_valid, magnitude, bin, out_last);
  modport slave  (input  in_valid, pixel, out_ready,
                  output in_ready, out_valid, magnitude, bin, out_last);
endinterface

// File: rtl/hog_gradient.sv
// hog_gradient: central-difference gradient, L1 magnitude and 9-bin unsigned
// orientation per pixel of a raster frame. Two line buffers hold rows y-1 and
// y-2; accepting pixel (x,y) produces the result for centre (x,y-1).
// Optional macro HOG_GRAD_BORDER_REPLICATE_EN: border pixels are computed with
// missing neighbours replaced by the centre pixel instead of forced to 0/0.
module hog_gradient #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int MAG_WIDTH    = DATA_WIDTH + 1
) (
  input  logic          clk,
  input  logic          rst,
  hog_gradient_if.slave s
);
  localparam int XW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int GW = DATA_WIDTH + 1;
  localparam int SW = (MAG_WIDTH > DATA_WIDTH + 2) ? MAG_WIDTH : DATA_WIDTH + 2;
  localparam int CW = DATA_WIDTH + 13;

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t                state, nstate;
  logic [XW-1:0]         x, xl, xr;
  logic [YW-1:0]         y;
  logic                  x_last, y_last, flushing, slot, rdy_en;
  logic                  in_ready_c, in_fire, ld_run, ld_flush;
  logic [DATA_WIDTH-1:0] lb1 [IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] lb2 [IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] lprev;
  logic [DATA_WIDTH-1:0] n_l, n_c, n_r, n_t, n_b;
  logic                  cx0, cxw, cy_top, cy_bot;
  logic signed [GW-1:0]  gx, gy, fx, fy;
  logic [GW-1:0]         ax, ay;
  logic [SW-1:0]         sum;
  logic [CW-1:0]         ays, axe;
  logic [2:0]            idx;
  logic [MAG_WIDTH-1:0]  mag_c, mag_q;
  logic [3:0]            bin_c, bin_q;
  logic                  out_valid_q, out_last_q;

  assign x_last   = (x == XW'(IMAGE_WIDTH - 1));
  assign y_last   = (y == YW'(IMAGE_HEIGHT - 1));
  assign xl       = (x == '0) ? x : x - 1'b1;
  assign xr       = x_last ? x : x + 1'b1;
  assign flushing = (state == FLUSH);
  assign slot     = !out_valid_q || s.out_ready;
  assign in_fire  = s.in_valid && in_ready_c;

  assign s.in_ready  = in_ready_c;
  assign s.out_valid = out_valid_q;
  assign s.magnitude = mag_q;
  assign s.bin       = bin_q;
  assign s.out_last  = out_last_q;

  // rdy_en keeps in_ready low while reset is asserted and for the first edge after
  always_ff @(posedge clk or negedge rst)
    if (!rst) rdy_en <= 1'b0;
    else      rdy_en <= 1'b1;

  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= FILL;
    else      state <= nstate;

  // next state; FLUSH ends when the last result is loaded, since in FILL the
  // slot term still holds off new pixels until that result has transferred
  always_comb begin
    nstate = state;
    case (state)
      FILL:    if (in_fire && x_last)           nstate = RUN;
      RUN:     if (in_fire && x_last && y_last) nstate = FLUSH;
      FLUSH:   if (ld_flush && x_last)          nstate = FILL;
      default: nstate = FILL;
    endcase
  end

  // FSM outputs: input handshake and output register load strobes
  always_comb begin
    in_ready_c = 1'b0;
    ld_run     = 1'b0;
    ld_flush   = 1'b0;
    case (state)
      FILL:  in_ready_c = rdy_en && slot;
      RUN: begin
        in_ready_c = rdy_en && slot;
        ld_run     = s.in_valid && rdy_en && slot;
      end
      FLUSH: ld_flush = slot;
      default: ;
    endcase
  end

  // raster counters; during FLUSH x walks the last row, y stays 0
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      x <= '0;
      y <= '0;
    end else if (in_fire || ld_flush) begin
      x <= x_last ? '0 : x + 1'b1;
      if (x_last && !flushing) y <= y_last ? '0 : y + 1'b1;
    end

  // line buffers: lb1 = previous row, lb2 = row before; lprev keeps the
  // overwritten lb1[x-1] so the left neighbour survives the write
  always_ff @(posedge clk)
    if (in_fire) begin
      lb1[x] <= s.pixel;
      lb2[x] <= n_c;
      lprev  <= n_c;
    end

  // neighbour window for the current centre (x,y-1), or (x,H-1) while flushing
  always_comb begin
    n_c    = lb1[x];
    n_r    = lb1[xr];
    n_t    = lb2[x];
    n_b    = s.pixel;
    n_l    = flushing ? lb1[xl] : lprev;
    cx0    = (x == '0);
    cxw    = x_last;
    cy_top = !flushing && (y == YW'(1));
    cy_bot = flushing;
`ifdef HOG_GRAD_BORDER_REPLICATE_EN
    if (cx0)    n_l = n_c;
    if (cxw)    n_r = n_c;
    if (cy_top) n_t = n_c;
    if (cy_bot) n_b = n_c;
`endif
  end

  // gradient, fold to gx>=0, saturated L1 magnitude, Q8 tangent-threshold bin
  always_comb begin
    gx = $signed({1'b0, n_r}) - $signed({1'b0, n_l});
    gy = $signed({1'b0, n_b}) - $signed({1'b0, n_t});
    fx = gx;
    fy = gy;
    if (gx[GW-1]) begin
      fx = -gx;
      fy = -gy;
    end
    ax    = fx;
    ay    = fy[GW-1] ? -fy : fy;
    sum   = SW'(ax) + SW'(ay);
    mag_c = (sum > SW'({MAG_WIDTH{1'b1}})) ? '1 : MAG_WIDTH'(sum);
    ays   = CW'(ay) << 8;
    axe   = CW'(ax);
    if      (ays < axe * CW'(93))   idx = 3'd0;
    else if (ays < axe * CW'(215))  idx = 3'd1;
    else if (ays < axe * CW'(443))  idx = 3'd2;
    else if (ays < axe * CW'(1452)) idx = 3'd3;
    else                            idx = 3'd4;
    if (ax == '0 && ay == '0)             bin_c = 4'd0;
    else if (fy[GW-1] && idx != 3'd4)     bin_c = 4'd8 - {1'b0, idx};
    else                                  bin_c = {1'b0, idx};
`ifndef HOG_GRAD_BORDER_REPLICATE_EN
    if (cx0 || cxw || cy_top || cy_bot) begin
      mag_c = '0;
      bin_c = '0;
    end
`endif
  end

  // output register: loads on a result, holds while stalled, drains on transfer
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid_q <= 1'b0;
      mag_q       <= '0;
      bin_q       <= '0;
      out_last_q  <= 1'b0;
    end else if (ld_run || ld_flush) begin
      out_valid_q <= 1'b1;
      mag_q       <= mag_c;
      bin_q       <= bin_c;
      out_last_q  <= ld_flush && x_last;
    end else if (s.out_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
endmodule

// File: doc/hog_gradient.md
Name: hog_gradient

Overview:
- Per-level consumer of one pyramid output stream (pixel plus valid/ready); first stage of the HOG feature path.
- Computes central-difference gradients gx, gy for every pixel of a raster frame.
- Emits, per pixel in raster order, the L1 magnitude and a 9-bin unsigned orientation (0-180 deg, 20 deg bins), ready for cell histogramming.
- One instance per pyramid level.

Parameters:
- DATA_WIDTH, 8, input pixel width (unsigned).
- IMAGE_WIDTH, 640, pixels per row of this level, >=3.
- IMAGE_HEIGHT, 480, rows per frame of this level, >=3.
- MAG_WIDTH, DATA_WIDTH+1, magnitude width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  pixel valid.
- pixel  input  DATA_WIDTH  raster-order pixel.
- in_ready  output  1  block accepts pixel this cycle.
- out_ready  input  1  downstream accepts output.
- out_valid  output  1  output valid.
- magnitude  output  MAG_WIDTH  |gx|+|gy|, saturated to all-ones.
- bin  output  4  orientation bin 0..8.
- out_last  output  1  marks the final pixel (W-1, H-1) of the frame.

Behaviour:
- Reset (rst low, async): out_valid=0, magnitude=0, bin=0, out_last=0, in_ready=0; state FILL; x=y=0. Line buffer contents don't care.
- Neighbours of centre (x,y): L=(x-1,y), R=(x+1,y), T=(x,y-1), B=(x,y+1).
  - gx = R-L; gy = B-T (signed, DATA_WIDTH+1 bits; +y is downward).
- Border pixels (x=0, x=W-1, y=0, y=H-1): magnitude=0, bin=0.
- Fold: if gx<0, negate gx and gy. Let ax=gx, ay=|gy|.
- Bin compare uses strict "<", Q8 constants 93, 215, 443, 1452: compare ay*256 against k*ax.
  - gy>=0: bin 0, 1, 2, 3 for the first constant satisfied; else 4.
  - gy<0: bin 8, 7, 6, 5 for the first constant satisfied; else 4.
  - ax=0 and ay=0: bin 0.
  - ax=0 and ay>0: bin 4.
- Handshake:
  - Input transfer on in_valid&&in_ready; output transfer on out_valid&&out_ready.
  - The output register holds its value while out_valid&&!out_ready.
  - in_ready = (state!=FLUSH) && (!out_valid || out_ready).
  - in_ready must not depend combinationally on in_valid.
- FSM:
  - FILL: accepts row 0, produces no output. On accepting (W-1, 0) go to RUN.
  - RUN: accepting pixel (x,y), y>=1, loads the output register on the next edge with the result for centre (x, y-1). Latency is 1 cycle after acceptance. On accepting (W-1, H-1) go to FLUSH.
  - FLUSH: in_ready=0. Emits W outputs for row H-1, one per output transfer, back-to-back when out_ready is held high. out_last is set with the last of these. After that transfer, go to FILL with x=y=0.
- Counters: x wraps at W-1 and increments y; y wraps at H-1.
- Simultaneous output transfer and input acceptance in the same cycle is legal; full throughput is 1 pixel/cycle.
- Total outputs per frame = W*H, in raster order.
- Reset mid-frame discards the partial frame; the next accepted pixel is (0,0).

Optional Feature:
- Macro: HOG_GRAD_BORDER_REPLICATE_EN.
- Defined: border pixels are computed, not forced to zero. A missing neighbour is replaced by the centre pixel.
  - Example: x=0 gives gx=R-C; y=H-1 gives gy=C-T.
  - The corner (0,0) uses both replacements.
  - Same fold and bin rules apply.
- Undefined: border outputs are magnitude=0, bin=0 as above.
- Latency, handshake, FSM and output count are identical either way.

Test Plan:
- W=8, H=6, constant pixel 100 every cycle, out_ready=1 -> 48 outputs, all magnitude=0, bin=0; out_last only on output 48; in_ready low exactly 8 cycles (FLUSH).
- Horizontal ramp pixel=10*x -> interior outputs magnitude=20, bin=0; border outputs 0/0.
- Vertical ramp pixel=10*y -> interior magnitude=20, bin=4. Reversed ramp pixel=200-10*y -> bin=4. Ramp pixel=10*x+10*y (gx=gy=20) -> bin 2 (256*20 >= 215*20, < 443*20).
- Diagonal pixel=10*x+(50-10*y) (gx=20, gy=-20) -> bin 6. Single pixel 255 at (3,3) in a 0 field -> centre (2,3): gx=255, gy=0, magnitude=255, bin=0. Centre (4,3): gx=-255 folds to 255, bin=0.
- Random out_ready (50%) and in_valid gaps over 3 frames -> output sequence matches the reference model, no loss or duplication, outputs stable while stalled.
- Assert rst low in the middle of row 3 -> outputs clear asynchronously; the next frame restarts at (0,0) and matches the model. With HOG_GRAD_BORDER_REPLICATE_EN, the horizontal ramp gives border x=0 magnitude 10, bin 0.
